// File: rtl/dmem_arbiter_if.sv
// Bundle of both master channels feeding the data-memory arbiter.
// Each master holds req with we/addr/wdata stable until it sees its single-cycle ack; err and rdata are valid only while ack is high.
interface dmem_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req0;
    logic                  req1;
    logic                  we0;
    logic                  we1;
    logic [DATA_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] wdata0;
    logic [DATA_WIDTH-1:0] wdata1;
    logic                  ack0;
    logic                  ack1;
    logic                  err0;
    logic                  err1;
    logic [DATA_WIDTH-1:0] rdata0;
    logic [DATA_WIDTH-1:0] rdata1;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  ack0, ack1, err0, err1, rdata0, rdata1
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output ack0, ack1, err0, err1, rdata0, rdata1
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin sequencer for the single-ported data memory.
// One access every three cycles (IDLE -> ACCESS -> RESP); rejected accesses never touch memory.
module dmem_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int MEMORY_DEPTH = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    dmem_arbiter_if.slave         bus,
    output logic                  owner,
    output logic                  mem_MemWrite,
    output logic                  mem_MemRead,
    output logic [DATA_WIDTH-1:0] mem_Address,
    output logic [DATA_WIDTH-1:0] mem_WriteData,
    input  logic [DATA_WIDTH-1:0] mem_ReadData,
    output logic [1:0]            dbgState
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [DATA_WIDTH-1:0] DEPTH_W = DATA_WIDTH'(MEMORY_DEPTH);

    state_t                state;
    state_t                stateNext;
    logic                  prioQ;
    logic                  ownerQ;
    logic                  errQ;
    logic [DATA_WIDTH-1:0] rdata0Q;
    logic [DATA_WIDTH-1:0] rdata1Q;

    logic                  anyReq;
    logic                  winner;
    logic [DATA_WIDTH-1:0] winAddr;
    logic                  curWe;
    logic [DATA_WIDTH-1:0] curAddr;
    logic [DATA_WIDTH-1:0] curWdata;

    // Full-width word index compare, so addresses near the top of the space never wrap into range.
    function automatic logic addrErr(input logic [DATA_WIDTH-1:0] a);
        return (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH_W);
    endfunction

    always_comb begin
        anyReq = bus.req0 | bus.req1;
        if (bus.req0 && bus.req1) begin
            winner = prioQ;
        end else begin
            winner = bus.req1;
        end
        winAddr = winner ? bus.addr1 : bus.addr0;
    end

    always_comb begin
        curWe    = ownerQ ? bus.we1    : bus.we0;
        curAddr  = ownerQ ? bus.addr1  : bus.addr0;
        curWdata = ownerQ ? bus.wdata1 : bus.wdata0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext     = state;
        mem_MemWrite  = 1'b0;
        mem_MemRead   = 1'b0;
        mem_Address   = '0;
        mem_WriteData = '0;
        case (state)
            IDLE: begin
                if (anyReq) begin
                    stateNext = ACCESS;
                end
            end
            ACCESS: begin
                mem_Address   = curAddr;
                mem_WriteData = curWdata;
                if (!errQ) begin
                    mem_MemWrite = curWe;
                    mem_MemRead  = ~curWe;
                end
                stateNext = RESP;
            end
            RESP: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Grant, error and read-data registers; rdata only moves on a completed read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prioQ   <= 1'b0;
            ownerQ  <= 1'b0;
            errQ    <= 1'b0;
            rdata0Q <= '0;
            rdata1Q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (anyReq) begin
                        ownerQ <= winner;
                        errQ   <= addrErr(winAddr);
                    end
                end
                ACCESS: begin
                    prioQ <= ~ownerQ;
                    if (!curWe) begin
                        if (ownerQ) begin
                            rdata1Q <= errQ ? '0 : mem_ReadData;
                        end else begin
                            rdata0Q <= errQ ? '0 : mem_ReadData;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Responses decode registered state only, so req has no combinational path to ack.
    assign bus.ack0   = (state == RESP) && !ownerQ;
    assign bus.ack1   = (state == RESP) &&  ownerQ;
    assign bus.err0   = (state == RESP) && !ownerQ && errQ;
    assign bus.err1   = (state == RESP) &&  ownerQ && errQ;
    assign bus.rdata0 = rdata0Q;
    assign bus.rdata1 = rdata1Q;

    assign owner    = (state != IDLE) && ownerQ;
    assign dbgState = state;

endmodule
